// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared types and constants for the SPI NOR flash word reader
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    GAP,
    RESP
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;
  localparam int         DATA_BITS = 32;
  localparam int         XFER_BITS = 64;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_phase.sv
// rtl/spi_sck_phase.sv - sck half-period timer, one-cycle strobe on the last cycle of each phase
module spi_sck_phase #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic phase_end_o
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = !clear_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || phase_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - mode-0 SPI master fetching one 32-bit word with the 03h READ command
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int DIV    = 2,
  parameter int CS_GAP = 2,
  parameter int BSWAP  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [23:0] req_addr_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        sck_o,
  output logic        ss_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int GW = $clog2(CS_GAP + 1);

  state_t        state_q, state_d;
  logic          sck_q, sck_d;
  logic          ss_q, ss_d;
  logic          mosi_q, mosi_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_data_q, resp_data_d;
  logic          phase_end;
  logic          phase_clear;

  assign phase_clear = !((state_q == LOW) || (state_q == HIGH));

  spi_sck_phase #(
    .DIV(DIV)
  ) u_phase (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (phase_clear),
    .phase_end_o(phase_end)
  );

  always_comb begin
    state_d      = state_q;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          tx_d      = {CMD_READ, req_addr_i};
          bit_cnt_d = '0;
          ss_d      = 1'b0;
          sck_d     = 1'b0;
          mosi_d    = CMD_READ[7];
          state_d   = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          state_d = HIGH;
          // miso still holds the bit the flash shifted out on the previous falling edge
          if (bit_cnt_q >= 6'(CMD_BITS + ADDR_BITS)) begin
            rx_d = {rx_q[30:0], miso_i};
          end
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          if (bit_cnt_q == 6'(XFER_BITS - 1)) begin
            ss_d      = 1'b1;
            mosi_d    = 1'b0;
            gap_cnt_d = '0;
            state_d   = GAP;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            tx_d      = {tx_q[30:0], 1'b0};
            mosi_d    = (bit_cnt_q < 6'(CMD_BITS + ADDR_BITS - 1)) ? tx_q[30] : 1'b0;
            state_d   = LOW;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GW'(CS_GAP - 1)) begin
          gap_cnt_d    = '0;
          resp_data_d  = (BSWAP != 0) ? bswap32(rx_q) : rx_q;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign sck_o        = sck_q;
  assign ss_o         = ss_q;
  assign mosi_o       = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - two reader instances (DIV=2/BSWAP=0, DIV=1/BSWAP=1) against a flash model
module tb_spi_flash_reader;

  localparam int CS_GAP = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, sck, ss, mosi, miso;
  logic [23:0] req_addr [2];
  logic [31:0] resp_data [2];
  wire  [31:0] rises [2];
  wire  [31:0] hdrs [2];

  logic [7:0] mem [int unsigned];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      w = {w[23:0], mem_byte(32'((a + 24'(k)) & 24'hFFFFFF))};
    end
    return w;
  endfunction

  function automatic logic flash_bit(input logic [23:0] a, input int i);
    logic [31:0] w;
    w = flash_word(a);
    return w[5'(31 - i)];
  endfunction

  function automatic int lat(input int idx);
    return 128 * ((idx == 0) ? 2 : 1) + CS_GAP;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    spi_flash_reader #(
      .DIV   ((g == 0) ? 2 : 1),
      .CS_GAP(CS_GAP),
      .BSWAP ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_ready_i(resp_ready[g]),
      .resp_data_o (resp_data[g]),
      .sck_o       (sck[g]),
      .ss_o        (ss[g]),
      .mosi_o      (mosi[g]),
      .miso_i      (miso[g])
    );

    // Flash: samples mosi on rising sck, shifts data out on falling sck after 32 header bits
    int          rise_r = 0;
    logic [31:0] hdr_r  = '0;
    logic        miso_r = 1'b0;

    always @(posedge sck[g] or negedge ss[g]) begin
      if (!sck[g]) begin
        rise_r <= 0;
        hdr_r  <= '0;
      end else if (!ss[g]) begin
        if (rise_r < 32) hdr_r <= {hdr_r[30:0], mosi[g]};
        rise_r <= rise_r + 1;
      end
    end

    always @(negedge sck[g]) begin
      if (!ss[g] && rise_r >= 32 && rise_r < 64) miso_r <= flash_bit(hdr_r[23:0], rise_r - 32);
    end

    assign miso[g]  = miso_r;
    assign rises[g] = 32'(rise_r);
    assign hdrs[g]  = hdr_r;
  end

  int ss_run  = 0;
  int min_gap = 1000;
  always @(negedge clk) begin
    if (ss[1]) begin
      ss_run <= ss_run + 1;
    end else begin
      if (ss_run > 0 && ss_run < min_gap) min_gap <= ss_run;
      ss_run <= 0;
    end
  end

  task automatic do_read(input int idx, input logic [23:0] addr, input int hold,
                         input bit tie, input bit glitch);
    logic [31:0] w, exp, held;
    int n;
    w   = flash_word(addr);
    exp = (idx == 1) ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
    @(negedge clk);
    resp_ready[idx] = tie;
    req_addr[idx]   = addr;
    req_valid[idx]  = 1'b1;
    n = 0;
    while (!req_ready[idx] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 64'(req_ready[idx]), 64'd1);
    @(posedge clk);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (glitch && n >= 20 && n < 24) begin
        req_valid[idx] = 1'b1;
        req_addr[idx]  = ~addr;
      end else begin
        req_valid[idx] = 1'b0;
        req_addr[idx]  = addr;
      end
      if (n == 10) begin
        chk("busy_req_ready", 64'(req_ready[idx]), 64'd0);
        chk("busy_ss", 64'(ss[idx]), 64'd0);
      end
      if (resp_valid[idx]) break;
      @(posedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat(idx)));
    chk("resp_data", 64'(resp_data[idx]), 64'(exp));
    chk("cmd_addr", 64'(hdrs[idx]), 64'({8'h03, addr}));
    chk("sck_rises", 64'(rises[idx]), 64'd64);
    held = resp_data[idx];
    if (!tie) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_stable", 64'({resp_valid[idx], resp_data[idx], req_ready[idx], sck[idx], ss[idx]}),
            64'({1'b1, held, 1'b0, 1'b0, 1'b1}));
      end
      resp_ready[idx] = 1'b1;
    end
    @(negedge clk);
    chk("accepted", 64'({resp_valid[idx], req_ready[idx]}), 64'b01);
    resp_ready[idx] = tie;
  endtask

  initial begin
    logic [23:0] ra;
    int idx, n;
    bit seen;
    req_valid   = '0;
    resp_ready  = '0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    mem[32'h100] = 8'hDE;
    mem[32'h101] = 8'hAD;
    mem[32'h102] = 8'hBE;
    mem[32'h103] = 8'hEF;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_pins", 64'({ss[i], sck[i], mosi[i], req_ready[i], resp_valid[i]}), 64'b10010);
      chk("reset_data", 64'(resp_data[i]), 64'd0);
    end
    rst_n = 1'b1;

    do_read(0, 24'h000100, 20, 1'b0, 1'b0);
    do_read(1, 24'h000100, 0, 1'b1, 1'b0);
    do_read(1, 24'h7FFFFC, 0, 1'b1, 1'b0);
    do_read(1, 24'h000000, 0, 1'b1, 1'b0);
    chk("ss_gap_min", 64'(min_gap >= CS_GAP + 1), 64'd1);
    do_read(0, 24'h123456, 3, 1'b0, 1'b1);
    do_read(1, 24'h654321, 0, 1'b1, 1'b1);

    for (int it = 0; it < 6; it++) begin
      idx = int'($urandom_range(0, 1));
      ra  = 24'($urandom_range(32'h1000, 32'hFFFFFF));
      for (int k = 0; k < 4; k++) mem[32'((ra + 24'(k)) & 24'hFFFFFF)] = 8'($urandom);
      do_read(idx, ra, int'($urandom_range(0, 5)), bit'(idx), bit'($urandom_range(0, 1)));
    end

    @(negedge clk);
    req_addr[0]  = 24'h000100;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rises[0] < 40 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_pulse40", 64'(rises[0]), 64'd40);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 64'({ss[0], sck[0], resp_valid[0]}), 64'b100);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (resp_valid[0]) seen = 1'b1;
    end
    chk("no_resp_after_reset", 64'(seen), 64'd0);
    do_read(0, 24'h000100, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
